// File: rtl/gate_bist_if.sv
// Host/gate-side signal bundle for the gate BIST sequencer.
// The master drives stimulus and gate response; the slave is the sequencer.
interface gate_bist_if #(
    parameter int N_IN = 2
);
    logic                 start;
    logic                 abort;
    logic [2**N_IN-1:0]   truth_tbl;
    logic                 gate_y;
    logic [N_IN-1:0]      gate_in;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [N_IN:0]        fail_cnt;
    logic [N_IN-1:0]      fail_idx;

    modport master (
        output start, abort, truth_tbl, gate_y,
        input  gate_in, busy, done, pass, fail_cnt, fail_idx
    );

    modport slave (
        input  start, abort, truth_tbl, gate_y,
        output gate_in, busy, done, pass, fail_cnt, fail_idx
    );
endinterface

// File: rtl/gate_bist_ctrl.sv
// Exhaustive-vector BIST sequencer for an N_IN-input combinational gate.
// Walks every input vector, samples gate_y after a settle window, scores it.
module gate_bist_ctrl #(
    parameter int N_IN          = 2,
    parameter int SETTLE_CYCLES = 2
) (
    input logic        clk,
    input logic        rst,
    gate_bist_if.slave bus
);
    localparam int NV = 2**N_IN;
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [N_IN-1:0] VEC_LAST = '1;

    typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

    state_t          state_q, state_d;
    logic [NV-1:0]   tbl_q, tbl_d;
    logic [N_IN-1:0] gate_in_q, gate_in_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            pass_q, pass_d;
    logic [N_IN:0]   fail_cnt_q, fail_cnt_d;
    logic [N_IN-1:0] fail_idx_q, fail_idx_d;
    logic            miss;

    assign miss = bus.gate_y != tbl_q[gate_in_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            tbl_q      <= '0;
            gate_in_q  <= '0;
            cnt_q      <= '0;
            pass_q     <= 1'b0;
            fail_cnt_q <= '0;
            fail_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            tbl_q      <= tbl_d;
            gate_in_q  <= gate_in_d;
            cnt_q      <= cnt_d;
            pass_q     <= pass_d;
            fail_cnt_q <= fail_cnt_d;
            fail_idx_q <= fail_idx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tbl_d      = tbl_q;
        gate_in_d  = gate_in_q;
        cnt_d      = cnt_q;
        pass_d     = pass_q;
        fail_cnt_d = fail_cnt_q;
        fail_idx_d = fail_idx_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d    = SETTLE;
                    tbl_d      = bus.truth_tbl;
                    gate_in_d  = '0;
                    cnt_d      = '0;
                    pass_d     = 1'b0;
                    fail_cnt_d = '0;
                    fail_idx_d = '0;
                end
            end
            SETTLE: begin
                if (bus.abort) begin
                    state_d   = IDLE;
                    gate_in_d = '0;
                    cnt_d     = '0;
                    pass_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) state_d = CHECK;
                end
            end
            CHECK: begin
                // abort wins over the compare of this cycle
                if (bus.abort) begin
                    state_d   = IDLE;
                    gate_in_d = '0;
                    cnt_d     = '0;
                    pass_d    = 1'b0;
                end else begin
                    if (miss) begin
                        fail_cnt_d = fail_cnt_q + 1'b1;
                        if (fail_cnt_q == '0) fail_idx_d = gate_in_q;
                    end
                    if (gate_in_q == VEC_LAST) begin
                        state_d = DONE;
                        pass_d  = (fail_cnt_d == '0);
                    end else begin
                        state_d   = SETTLE;
                        gate_in_d = gate_in_q + 1'b1;
                        cnt_d     = '0;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.gate_in  = gate_in_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = (state_q == DONE);
    assign bus.pass     = pass_q;
    assign bus.fail_cnt = fail_cnt_q;
    assign bus.fail_idx = fail_idx_q;
endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Randomised scoreboard bench for gate_bist_ctrl.
// Expected results come from a truth-table comparison model.
module tb_gate_bist_ctrl;
    localparam int N   = 2;
    localparam int S   = 2;
    localparam int NV  = 1 << N;
    localparam int PER = S + 1;
    localparam int LAT = NV * PER;

    typedef struct {
        logic       pass;
        logic [N:0] cnt;
        logic [N-1:0] idx;
        int         due;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic [NV-1:0] beh;
    exp_t sb[$];
    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    int track = -1;

    gate_bist_if #(.N_IN(N)) bus();

    gate_bist_ctrl #(.N_IN(N), .SETTLE_CYCLES(S)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // gate-under-test: arbitrary behaviour table indexed by its inputs
    assign bus.gate_y = beh[bus.gate_in];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(logic [NV-1:0] tbl, logic [NV-1:0] g,
                                   int due);
        exp_t e;
        int c = 0;
        e.idx = '0;
        for (int v = 0; v < NV; v++) begin
            if (g[v] != tbl[v]) begin
                if (c == 0) e.idx = v[N-1:0];
                c++;
            end
        end
        e.cnt  = c[N:0];
        e.pass = (c == 0);
        e.due  = due;
        return e;
    endfunction

    // monitor: vector walk while tracked, results whenever done pulses
    always @(negedge clk) begin
        int k, ev;
        exp_t e;
        if (!rst) begin
            if (track >= 0 && bus.busy) begin
                k  = cyc - track;
                ev = k / PER;
                if (ev > NV - 1) ev = NV - 1;
                chk("gate_in_seq", bus.gate_in, ev);
            end
            if (bus.done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("done_cycle", cyc, e.due);
                    chk("pass", bus.pass, e.pass);
                    chk("fail_cnt", bus.fail_cnt, e.cnt);
                    chk("fail_idx", bus.fail_idx, e.idx);
                    chk("busy_in_done", bus.busy, 1);
                end
            end
        end
    end

    task automatic kick(logic [NV-1:0] tbl, logic [NV-1:0] g, bit with_abort);
        beh = g;
        bus.truth_tbl = tbl;
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.abort = with_abort;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        track = cyc;
    endtask

    // opts: bit0 restart pulses, bit1 abort in DONE, bit2 abort with start
    task automatic run(logic [NV-1:0] tbl, logic [NV-1:0] g, int opts,
                       bit scramble);
        exp_t e;
        kick(tbl, g, opts[2]);
        e = model(tbl, g, cyc + LAT);
        sb.push_back(e);
        for (int k = 0; k < LAT + 2; k++) begin
            if (scramble) bus.truth_tbl = NV'($urandom);
            bus.start = opts[0] && (k == 3 || k == 8);
            bus.abort = opts[1] && (k == LAT);
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        track = -1;
        chk("done_seen", sb.size(), 0);
        sb.delete();
        chk("idle_after", bus.busy, 0);
        chk("hold_fail_cnt", bus.fail_cnt, e.cnt);
        chk("hold_pass", bus.pass, e.pass);
    endtask

    task automatic abort_case();
        kick(4'b1110, 4'b1111, 1'b0);
        repeat (4) begin @(posedge clk); #1; end
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        track = -1;
        chk("abort_busy", bus.busy, 0);
        chk("abort_pass", bus.pass, 0);
        chk("abort_fail_cnt", bus.fail_cnt, 1);
        chk("abort_fail_idx", bus.fail_idx, 0);
        chk("abort_gate_in", bus.gate_in, 0);
        repeat (LAT) @(posedge clk);
        #1;
    endtask

    task automatic reset_case();
        kick(4'b1110, 4'b1111, 1'b0);
        repeat (4) begin @(posedge clk); #1; end
        track = -1;
        #2 rst = 1'b1;
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_gate_in", bus.gate_in, 0);
        chk("rst_fail_cnt", bus.fail_cnt, 0);
        chk("rst_fail_idx", bus.fail_idx, 0);
        chk("rst_pass", bus.pass, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (LAT) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [NV-1:0] t, g;
        logic [NV-1:0] models [4];
        models[0] = 4'b1110;
        models[1] = 4'b1000;
        models[2] = 4'b1111;
        models[3] = 4'b0000;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.truth_tbl = '0;
        beh = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", bus.busy, 0);
        chk("reset_done", bus.done, 0);
        chk("reset_pass", bus.pass, 0);
        chk("reset_fail_cnt", bus.fail_cnt, 0);
        chk("reset_fail_idx", bus.fail_idx, 0);
        chk("reset_gate_in", bus.gate_in, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        run(4'b1110, 4'b1110, 0, 1'b0);
        run(4'b1000, 4'b1110, 0, 1'b1);
        run(4'b1110, 4'b1111, 0, 1'b1);
        run(4'b1110, 4'b1110, 1, 1'b1);
        abort_case();
        run(4'b1110, 4'b1110, 0, 1'b0);
        reset_case();
        run(4'b1110, 4'b1110, 0, 1'b0);
        run(4'b0001, 4'b1110, 2, 1'b1);
        run(4'b0111, 4'b1111, 4, 1'b0);

        for (int i = 0; i < 12; i++) begin
            t = NV'($urandom);
            if ($urandom_range(0, 1) == 0)
                g = models[$urandom_range(0, 3)];
            else
                g = NV'($urandom);
            run(t, g, int'($urandom_range(0, 7)), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
